// File: rtl/von_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit von Neumann datapath.
// Fetches one-byte instructions, triggers the external ALU by toggling alu_activate and writes its result to AC.
module von_control_unit #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] alu_ac,
    output logic [DATA_W-1:0] alu_dr,
    output logic [2:0]        alu_mode,
    output logic              alu_activate,
    input  logic [DATA_W-1:0] alu_result,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] ac_out
);
    generate
        if (DATA_W != ADDR_W + 3) begin : g_width_check
            $error("von_control_unit: DATA_W must equal ADDR_W + 3");
        end
    endgenerate

    localparam logic [2:0] OP_STORE = 3'b101;
    localparam logic [2:0] OP_NEG   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_IR_LOAD,
        S_DECODE,
        S_OPERAND,
        S_EXEC,
        S_WB,
        S_STORE,
        S_HALT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ac;
    logic [DATA_W-1:0] dr;
    logic [DATA_W-1:0] ir;
    logic              act;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic              needs_operand;

    assign opcode        = ir[DATA_W-1 -: 3];
    assign operand       = ir[ADDR_W-1:0];
    assign needs_operand = (opcode != OP_STORE) && (opcode != OP_NEG) && (opcode != OP_HALT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
            pc    <= ADDR_W'(RESET_PC);
            ac    <= '0;
            dr    <= '0;
            ir    <= '0;
            act   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) state <= S_FETCH;
                end
                S_FETCH: begin
                    state <= S_IR_LOAD;
                end
                S_IR_LOAD: begin
                    ir    <= mem_rdata;
                    pc    <= pc + ADDR_W'(1);
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_HALT:  state <= S_HALT;
                        OP_STORE: state <= S_STORE;
                        OP_NEG:   state <= S_EXEC;
                        default:  state <= S_OPERAND;
                    endcase
                end
                S_OPERAND: begin
                    dr    <= mem_rdata;
                    state <= S_EXEC;
                end
                // Every level change of alu_activate requests exactly one ALU evaluation.
                S_EXEC: begin
                    act   <= ~act;
                    state <= S_WB;
                end
                S_WB: begin
                    ac    <= alu_result;
                    state <= run ? S_FETCH : S_IDLE;
                end
                S_STORE: begin
                    state <= run ? S_FETCH : S_IDLE;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory strobes depend only on registered state (and the registered IR in DECODE/STORE).
    always_comb begin
        mem_addr = pc;
        mem_rd   = 1'b0;
        mem_we   = 1'b0;
        case (state)
            S_FETCH: begin
                mem_rd = 1'b1;
            end
            S_DECODE: begin
                mem_addr = operand;
                mem_rd   = needs_operand;
            end
            S_STORE: begin
                mem_addr = operand;
                mem_we   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign halted       = (state == S_HALT);
    assign mem_wdata    = ac;
    assign alu_ac       = ac;
    assign alu_dr       = dr;
    assign alu_mode     = opcode;
    assign alu_activate = act;
    assign pc_out       = pc;
    assign ac_out       = ac;

endmodule
